// File: rtl/sha256_message_build_if.sv
// Handshake bundle between a message source, the block builder and the
// SHA-256 compression stage that consumes the finished 512-bit blocks.
interface sha256_message_build_if;
  logic [31:0]  data_in;
  logic [2:0]   data_in_bytes;
  logic [5:0]   data_in_id;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [511:0] data_out;
  logic [5:0]   data_out_id;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;

  modport master (
    output data_in, data_in_bytes, data_in_id, data_in_last, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_id, data_out_last, data_out_valid
  );

  modport slave (
    input  data_in, data_in_bytes, data_in_id, data_in_last, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_id, data_out_last, data_out_valid
  );
endinterface

// File: rtl/sha256_message_build.sv
// Packs a stream of big-endian 32-bit words into SHA-256 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit message bit length.
module sha256_message_build (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic sync_rst,
  sha256_message_build_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, PAD, EMIT} state_t;

  state_t       state_reg, state_next;
  logic [31:0]  blk_reg [16];
  logic [511:0] blk_flat;
  logic [3:0]   widx_reg, widx_next;
  logic [63:0]  len_reg, len_next;
  logic         marker_done_reg, marker_done_next;
  logic         lenhi_done_reg, lenhi_done_next;
  logic         first_word_reg, first_word_next;
  logic         final_seen_reg, final_seen_next;
  logic [5:0]   id_reg, id_next;
  logic         last_reg, last_next;
  logic         valid_reg, valid_next;
  logic         wr_en;
  logic [31:0]  wr_data;
  logic [31:0]  tail_word;
  logic         in_hs, out_hs;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_flat
      assign blk_flat[511-32*gi -: 32] = blk_reg[gi];
    end
  endgenerate

  assign bus.data_out       = blk_flat;
  assign bus.data_out_id    = id_reg;
  assign bus.data_out_last  = last_reg;
  assign bus.data_out_valid = valid_reg;
  assign bus.data_in_ready  = en && (state_reg == COLLECT);

  assign in_hs  = bus.data_in_valid && bus.data_in_ready;
  assign out_hs = en && valid_reg && bus.data_out_ready;

  // Final partial word: keep the valid top bytes and place the marker right after them.
  always_comb begin
    case (bus.data_in_bytes)
      3'd0:    tail_word = 32'h8000_0000;
      3'd1:    tail_word = {bus.data_in[31:24], 24'h80_0000};
      3'd2:    tail_word = {bus.data_in[31:16], 16'h8000};
      3'd3:    tail_word = {bus.data_in[31:8], 8'h80};
      default: tail_word = bus.data_in;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    widx_next        = widx_reg;
    len_next         = len_reg;
    marker_done_next = marker_done_reg;
    lenhi_done_next  = lenhi_done_reg;
    first_word_next  = first_word_reg;
    final_seen_next  = final_seen_reg;
    id_next          = id_reg;
    last_next        = last_reg;
    valid_next       = valid_reg;
    wr_en            = 1'b0;
    wr_data          = 32'h0;

    case (state_reg)
      COLLECT: begin
        if (in_hs) begin
          wr_en    = 1'b1;
          wr_data  = bus.data_in_last ? tail_word : bus.data_in;
          len_next = len_reg + {58'd0, bus.data_in_bytes, 3'b000};
          if (first_word_reg) begin
            id_next         = bus.data_in_id;
            first_word_next = 1'b0;
          end
          if (bus.data_in_last) begin
            final_seen_next  = 1'b1;
            marker_done_next = (bus.data_in_bytes != 3'd4);
          end
          if (widx_reg == 4'd15) begin
            state_next = EMIT;
            last_next  = 1'b0;
            valid_next = 1'b1;
          end else begin
            widx_next = widx_reg + 4'd1;
            if (bus.data_in_last) state_next = PAD;
          end
        end
      end

      PAD: begin
        wr_en = 1'b1;
        if (!marker_done_reg) begin
          wr_data          = 32'h8000_0000;
          marker_done_next = 1'b1;
        end else if (widx_reg == 4'd14) begin
          wr_data         = len_reg[63:32];
          lenhi_done_next = 1'b1;
        end else if (widx_reg == 4'd15 && lenhi_done_reg) begin
          wr_data = len_reg[31:0];
        end
        // Word 15 always closes the block; it is final only if the length landed in it.
        if (widx_reg == 4'd15) begin
          state_next = EMIT;
          last_next  = marker_done_reg && lenhi_done_reg;
          valid_next = 1'b1;
        end else begin
          widx_next = widx_reg + 4'd1;
        end
      end

      default: begin
        if (out_hs) begin
          valid_next      = 1'b0;
          widx_next       = 4'd0;
          lenhi_done_next = 1'b0;
          if (last_reg) begin
            len_next         = 64'd0;
            marker_done_next = 1'b0;
            first_word_next  = 1'b1;
            final_seen_next  = 1'b0;
            state_next       = COLLECT;
          end else if (final_seen_reg) begin
            state_next = PAD;
          end else begin
            state_next = COLLECT;
          end
        end
      end
    endcase

    if (sync_rst) begin
      state_next       = COLLECT;
      widx_next        = 4'd0;
      len_next         = 64'd0;
      marker_done_next = 1'b0;
      lenhi_done_next  = 1'b0;
      first_word_next  = 1'b1;
      final_seen_next  = 1'b0;
      id_next          = 6'd0;
      last_next        = 1'b0;
      valid_next       = 1'b0;
      wr_en            = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg       <= COLLECT;
      widx_reg        <= 4'd0;
      len_reg         <= 64'd0;
      marker_done_reg <= 1'b0;
      lenhi_done_reg  <= 1'b0;
      first_word_reg  <= 1'b1;
      final_seen_reg  <= 1'b0;
      id_reg          <= 6'd0;
      last_reg        <= 1'b0;
      valid_reg       <= 1'b0;
      for (int i = 0; i < 16; i++) blk_reg[i] <= 32'h0;
    end else if (en || sync_rst) begin
      state_reg       <= state_next;
      widx_reg        <= widx_next;
      len_reg         <= len_next;
      marker_done_reg <= marker_done_next;
      lenhi_done_reg  <= lenhi_done_next;
      first_word_reg  <= first_word_next;
      final_seen_reg  <= final_seen_next;
      id_reg          <= id_next;
      last_reg        <= last_next;
      valid_reg       <= valid_next;
      if (sync_rst) begin
        for (int i = 0; i < 16; i++) blk_reg[i] <= 32'h0;
      end else if (wr_en) begin
        blk_reg[widx_reg] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_sha256_message_build.sv
// Directed and randomized stimulus for the SHA-256 message builder, checked
// against a byte-level padding model of FIPS 180-4.
module tb_sha256_message_build;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b1;
  logic sync_rst = 1'b0;
  always #5 clk = ~clk;

  sha256_message_build_if ifc ();

  sha256_message_build dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .sync_rst (sync_rst),
    .bus      (ifc)
  );

  typedef struct {
    logic [511:0] d;
    logic [5:0]   id;
    logic         last;
  } blk_t;

  blk_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           blk_cnt = 0;
  int           exp_total = 0;
  logic [511:0] last_d = '0;
  bit           hold_low = 1'b0;
  bit           rand_mode = 1'b0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: standard byte-oriented padding, then cut into 64-byte blocks.
  task automatic push_model(input logic [7:0] m[$], input logic [5:0] id);
    logic [7:0]  p[$];
    logic [63:0] bits;
    int          nblk;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      blk_t e;
      for (int i = 0; i < 64; i++) e.d[511-8*i -: 8] = p[64*b+i];
      e.id = id;
      e.last = (b == nblk - 1);
      exp_q.push_back(e);
      exp_total++;
    end
  endtask

  task automatic make_msg(input int n, output logic [7:0] m[$]);
    m.delete();
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
  endtask

  // complete=0 sends whole words without a final word and expects nothing.
  task automatic send_msg(input logic [7:0] m[$], input logic [5:0] id, input bit complete);
    int nw;
    nw = (m.size() == 0) ? 1 : (m.size() + 3) / 4;
    if (complete) push_model(m, id);
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word;
      int          nb;
      int          guard;
      bit          hs;
      word = $urandom;
      for (int i = 0; i < 4; i++)
        if (4*w + i < m.size()) word[31-8*i -: 8] = m[4*w+i];
      nb = m.size() - 4*w;
      if (nb > 4) nb = 4;
      if (nb < 0) nb = 0;
      ifc.data_in       = word;
      ifc.data_in_bytes = 3'(nb);
      ifc.data_in_id    = (w == 0) ? id : 6'($urandom);
      ifc.data_in_last  = complete && (w == nw - 1);
      ifc.data_in_valid = 1'b1;
      guard = 0;
      hs = 1'b0;
      while (!hs && guard < 5000) begin
        @(negedge clk);
        hs = ifc.data_in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!hs) check("in_handshake_timeout", 512'(hs), 512'd1);
    end
    ifc.data_in_valid = 1'b0;
    ifc.data_in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", 512'(exp_q.size()), 512'd0);
  endtask

  initial begin
    ifc.data_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ifc.data_out_ready = hold_low ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  always @(negedge clk) begin
    if (nrst && en && !sync_rst && ifc.data_out_valid && ifc.data_out_ready) begin
      blk_t e;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_block: observed id %0d expected no block", ifc.data_out_id);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("blk_data", ifc.data_out, e.d);
        check("blk_id", 512'(ifc.data_out_id), 512'(e.id));
        check("blk_last", 512'(ifc.data_out_last), 512'(e.last));
      end
      last_d = ifc.data_out;
      blk_cnt++;
    end
  end

  initial begin
    logic [7:0]   m[$];
    logic [511:0] abc_blk;
    logic [511:0] held;
    int           cyc;
    abc_blk = {32'h6162_6380, 448'd0, 32'h0000_0018};
    ifc.data_in = '0;
    ifc.data_in_bytes = '0;
    ifc.data_in_id = '0;
    ifc.data_in_last = 1'b0;
    ifc.data_in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", ifc.data_out, 512'd0);
    check("rst_id", 512'(ifc.data_out_id), 512'd0);
    check("rst_last", 512'(ifc.data_out_last), 512'd0);
    check("rst_valid", 512'(ifc.data_out_valid), 512'd0);
    nrst = 1'b1;
    #1;
    check("rst_in_ready", 512'(ifc.data_in_ready), 512'd1);

    // "abc" with latency measurement
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 6'd5, 1'b1);
    cyc = 1;
    while (!ifc.data_out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abc_latency", 512'(cyc), 512'd16);
    wait_drain();
    check("abc_block", last_d, abc_blk);

    m.delete();
    send_msg(m, 6'd9, 1'b1);
    wait_drain();
    check("empty_block", last_d, {32'h8000_0000, 480'd0});

    // Length boundaries around the marker/length fit
    make_msg(56, m); send_msg(m, 6'd12, 1'b1); wait_drain();
    check("len56_tail", last_d, {480'd0, 32'h0000_01C0});
    make_msg(64, m); send_msg(m, 6'd13, 1'b1); wait_drain();
    check("len64_tail", last_d, {32'h8000_0000, 448'd0, 32'h0000_0200});
    make_msg(60, m); send_msg(m, 6'd14, 1'b1); wait_drain();
    make_msg(55, m); send_msg(m, 6'd15, 1'b1); wait_drain();
    make_msg(52, m); send_msg(m, 6'd16, 1'b1); wait_drain();

    en = 1'b0;
    @(posedge clk);
    #1;
    check("en_low_in_ready", 512'(ifc.data_in_ready), 512'd0);
    en = 1'b1;

    // Backpressure: output held, then a second message follows in order
    hold_low = 1'b1;
    make_msg(12, m);
    send_msg(m, 6'd1, 1'b1);
    cyc = 0;
    while (!ifc.data_out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    held = ifc.data_out;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_valid", 512'(ifc.data_out_valid), 512'd1);
      check("bp_stable", ifc.data_out, held);
      check("bp_in_ready", 512'(ifc.data_in_ready), 512'd0);
    end
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("en_low_valid_hold", 512'(ifc.data_out_valid), 512'd1);
    en = 1'b1;
    hold_low = 1'b0;
    make_msg(7, m);
    send_msg(m, 6'd2, 1'b1);
    wait_drain();

    // Mid-message asynchronous reset
    make_msg(28, m);
    send_msg(m, 6'd33, 1'b0);
    nrst = 1'b0;
    #1;
    check("arst_data", ifc.data_out, 512'd0);
    check("arst_id", 512'(ifc.data_out_id), 512'd0);
    check("arst_valid", 512'(ifc.data_out_valid), 512'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 6'd5, 1'b1);
    wait_drain();
    check("arst_abc_block", last_d, abc_blk);

    // Mid-message synchronous reset
    make_msg(28, m);
    send_msg(m, 6'd34, 1'b0);
    sync_rst = 1'b1;
    @(posedge clk);
    #1;
    check("srst_data", ifc.data_out, 512'd0);
    check("srst_id", 512'(ifc.data_out_id), 512'd0);
    sync_rst = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 6'd5, 1'b1);
    wait_drain();
    check("srst_abc_block", last_d, abc_blk);

    // Random lengths, ids and output stalls
    rand_mode = 1'b1;
    repeat (25) begin
      make_msg(int'($urandom_range(0, 140)), m);
      send_msg(m, 6'($urandom), 1'b1);
    end
    wait_drain();
    rand_mode = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("block_count", 512'(blk_cnt), 512'(exp_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
